// File: rtl/serial_shift_rx.sv
// serial_shift_rx: oversampling receiver for the serial shift-chain (clock/data/clear/latch) protocol
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   ser_clk, ser_data  asynchronous serial shift clock and data (data valid at ser_clk rise)
//   ser_clrn           asynchronous active-low shift-register clear
//   ser_pen            asynchronous latch strobe, rising edge ends the frame
//   data_out, valid    last latched word and its one-cycle update pulse
//   bit_count, busy    bits in the current frame (saturating at WIDTH+1), nonzero flag
//   frame_err          last latched frame did not contain exactly WIDTH bits
module serial_shift_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ser_clk,
    input  logic                       ser_data,
    input  logic                       ser_clrn,
    input  logic                       ser_pen,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid,
    output logic [$clog2(WIDTH+2)-1:0] bit_count,
    output logic                       frame_err,
    output logic                       busy
);
    localparam int CW = $clog2(WIDTH+2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH+1);
    // Line order in every sync stage is {pen, clrn, data, clk}; idle is clrn high, rest low.
    localparam logic [3:0] IDLE = 4'b0100;

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic                        r_hist_clk;
    logic                        r_hist_pen;
    logic [WIDTH-1:0]            r_sreg;
    logic [CW-1:0]               r_cnt;
    logic [WIDTH-1:0]            r_data_out;
    logic                        r_valid;
    logic                        r_frame_err;

    logic [3:0]                  w_sync;
    logic                        w_shift;
    logic                        w_latch;
    logic                        w_clr;
    logic [WIDTH-1:0]            w_sreg_next;
    logic [CW-1:0]               w_cnt_next;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_shift = w_sync[0] & ~r_hist_clk;
    assign w_latch = w_sync[3] & ~r_hist_pen;
    assign w_clr   = ~w_sync[2];

    // Clear dominates shift; the latch below samples these next values so a bit
    // shifted (or a clear applied) in the latch cycle is part of the word.
    assign w_sreg_next = w_clr ? '0 : w_shift ? {r_sreg[WIDTH-2:0], w_sync[1]} : r_sreg;
    assign w_cnt_next  = w_clr ? '0 : (w_shift && r_cnt != CNT_MAX) ? r_cnt + CW'(1) : r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= {SYNC_STAGES{IDLE}};
            r_hist_clk  <= 1'b0;
            r_hist_pen  <= 1'b0;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], ser_pen, ser_clrn, ser_data, ser_clk};
            r_hist_clk <= w_sync[0];
            r_hist_pen <= w_sync[3];
            r_sreg     <= w_sreg_next;
            r_cnt      <= w_latch ? '0 : w_cnt_next;
            r_valid    <= w_latch;
            if (w_latch) begin
                r_data_out  <= w_sreg_next;
                r_frame_err <= w_cnt_next != CNT_FULL;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid     = r_valid;
    assign bit_count = r_cnt;
    assign frame_err = r_frame_err;
    assign busy      = r_cnt != '0;
endmodule

// File: tb/tb_serial_shift_rx.sv
// tb_serial_shift_rx: random and directed frames into 16- and 64-bit receivers checked against a queue model
module tb_serial_shift_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser_clk = 1'b0;
    logic ser_data = 1'b0;
    logic ser_clrn = 1'b1;
    logic ser_pen = 1'b0;

    logic [15:0] d16;
    logic        v16, fe16, b16;
    logic [4:0]  bc16;
    logic [63:0] d64;
    logic        v64, fe64, b64;
    logic [6:0]  bc64;

    int n_cmp = 0;
    int n_err = 0;

    serial_shift_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data), .ser_clrn(ser_clrn),
        .ser_pen(ser_pen), .data_out(d16), .valid(v16), .bit_count(bc16), .frame_err(fe16), .busy(b16)
    );

    serial_shift_rx #(.WIDTH(64), .SYNC_STAGES(2)) dut64 (
        .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data), .ser_clrn(ser_clrn),
        .ser_pen(ser_pen), .data_out(d64), .valid(v64), .bit_count(bc64), .frame_err(fe64), .busy(b64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pins seen at each clk edge; an event becomes visible in the outputs two edges
    // after the edge that first captured the new pin level.
    localparam logic [3:0] IDLE = 4'b0100;
    logic [3:0] p_edge;
    logic       r_edge;
    always @(posedge clk) begin
        p_edge <= {ser_pen, ser_clrn, ser_data, ser_clk};
        r_edge <= rst;
    end

    logic [3:0] pq[$];
    bit         q16[$];
    bit         q64[$];
    int         m_cnt[2];
    logic [63:0] m_dout[2];
    bit         m_vld[2];
    bit         m_ferr[2];
    bit         m_ok = 0;

    function automatic logic [63:0] pack(input bit q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = {v[62:0], q[i]};
        return v;
    endfunction

    initial forever begin
        @(negedge clk);
        if (r_edge) begin
            pq = '{IDLE, IDLE, IDLE};
            q16.delete();
            q64.delete();
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_dout[i] = '0; m_vld[i] = 0; m_ferr[i] = 0;
            end
            m_ok = 1;
        end else if (m_ok) begin
            bit sh, la, cl, dv;
            sh = pq[1][0] && !pq[0][0];
            la = pq[1][3] && !pq[0][3];
            cl = !pq[1][2];
            dv = pq[1][1];
            if (cl) begin
                q16.delete(); q64.delete(); m_cnt[0] = 0; m_cnt[1] = 0;
            end else if (sh) begin
                q16.push_back(dv);
                q64.push_back(dv);
                if (q16.size() > 16) void'(q16.pop_front());
                if (q64.size() > 64) void'(q64.pop_front());
                if (m_cnt[0] < 17) m_cnt[0]++;
                if (m_cnt[1] < 65) m_cnt[1]++;
            end
            m_vld[0] = la;
            m_vld[1] = la;
            if (la) begin
                m_dout[0] = pack(q16);
                m_dout[1] = pack(q64);
                m_ferr[0] = m_cnt[0] != 16;
                m_ferr[1] = m_cnt[1] != 64;
                m_cnt[0] = 0;
                m_cnt[1] = 0;
            end
            void'(pq.pop_front());
            pq.push_back(p_edge);
        end
        if (m_ok) begin
            chk("m16_data", {48'h0, d16}, m_dout[0]);
            chk("m16_valid", {63'h0, v16}, {63'h0, m_vld[0]});
            chk("m16_count", {59'h0, bc16}, 64'(m_cnt[0]));
            chk("m16_ferr", {63'h0, fe16}, {63'h0, m_ferr[0]});
            chk("m16_busy", {63'h0, b16}, {63'h0, m_cnt[0] != 0});
            chk("m64_data", d64, m_dout[1]);
            chk("m64_valid", {63'h0, v64}, {63'h0, m_vld[1]});
            chk("m64_count", {57'h0, bc64}, 64'(m_cnt[1]));
            chk("m64_ferr", {63'h0, fe64}, {63'h0, m_ferr[1]});
            chk("m64_busy", {63'h0, b64}, {63'h0, m_cnt[1] != 0});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input int h);
        ser_data = b;
        tick(h);
        ser_clk = 1'b1;
        tick(h);
        ser_clk = 1'b0;
        tick(h);
    endtask

    task automatic send_word(input logic [63:0] v, input int n, input int h);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], h);
    endtask

    task automatic send_bit_latch(input bit b, input int h);
        ser_data = b;
        tick(h);
        ser_clk = 1'b1;
        ser_pen = 1'b1;
        tick(h);
        ser_clk = 1'b0;
        ser_pen = 1'b0;
        tick(h);
    endtask

    task automatic latch(input int h);
        ser_pen = 1'b1;
        tick(h);
        ser_pen = 1'b0;
        tick(h);
    endtask

    task automatic clear(input int h);
        ser_clrn = 1'b0;
        tick(h);
        ser_clrn = 1'b1;
        tick(h);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic random_frame();
        int n, h, clr_at, rst_at;
        bit sim;
        n = $urandom_range(0, 70);
        h = $urandom_range(2, 4);
        clr_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n) : -1;
        rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n) : -1;
        sim = ($urandom_range(0, 5) == 0) && n > 0;
        for (int i = 0; i < n; i++) begin
            if (i == clr_at) clear(h);
            if (i == rst_at) do_rst();
            if (sim && i == n - 1) send_bit_latch(1'($urandom_range(0, 1)), h);
            else send_bit(1'($urandom_range(0, 1)), h);
        end
        if (!sim) latch(h);
    endtask

    logic [63:0] w64 = 64'h0123_4567_89AB_CDEF;
    int lat;

    initial begin
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_data16", {48'h0, d16}, 64'h0);
        chk("reset_count16", {59'h0, bc16}, 64'h0);

        // 0xA5C3, half period 5, latency of valid from the strobe rise
        send_word(64'hA5C3, 16, 5);
        ser_pen = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (v16) begin
                lat = k;
                break;
            end
        end
        chk("valid_latency", 64'(lat), 64'd3);
        @(negedge clk);
        chk("valid_width", {63'h0, v16}, 64'h0);
        tick(3);
        ser_pen = 1'b0;
        tick(5);
        chk("a5c3_data", {48'h0, d16}, 64'hA5C3);
        chk("a5c3_ferr", {63'h0, fe16}, 64'h0);
        chk("a5c3_count", {59'h0, bc16}, 64'h0);

        // 18 bits: count saturates at 17, last 16 bits latched, error flagged
        send_word(64'h3, 2, 3);
        send_word(64'h1234, 16, 3);
        chk("sat_count", {59'h0, bc16}, 64'd17);
        latch(3);
        chk("long_data", {48'h0, d16}, 64'h1234);
        chk("long_ferr", {63'h0, fe16}, 64'h1);

        // partial frame discarded by a clear; output word untouched meanwhile
        send_word(64'hFF, 8, 2);
        chk("pre_clear_count", {59'h0, bc16}, 64'd8);
        ser_clrn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("clear_hold_data", {48'h0, d16}, 64'h1234);
        end
        chk("clear_count", {59'h0, bc16}, 64'h0);
        ser_clrn = 1'b1;
        tick(3);
        send_word(64'h0F0F, 16, 2);
        latch(2);
        chk("clear_data", {48'h0, d16}, 64'h0F0F);
        chk("clear_ferr", {63'h0, fe16}, 64'h0);

        // last shift and latch strobe detected in the same cycle
        send_word(64'h4000, 15, 3);
        send_bit_latch(1'b1, 3);
        chk("sim_data", {48'h0, d16}, 64'h8001);
        chk("sim_ferr", {63'h0, fe16}, 64'h0);

        // reset in mid-frame
        send_word(64'h2AA, 10, 2);
        rst = 1'b1;
        tick(1);
        chk("rst_data16", {48'h0, d16}, 64'h0);
        chk("rst_valid16", {63'h0, v16}, 64'h0);
        chk("rst_count16", {59'h0, bc16}, 64'h0);
        chk("rst_ferr16", {63'h0, fe16}, 64'h0);
        chk("rst_busy16", {63'h0, b16}, 64'h0);
        chk("rst_data64", d64, 64'h0);
        chk("rst_busy64", {63'h0, b64}, 64'h0);
        rst = 1'b0;
        tick(2);
        send_word(64'hBEEF, 16, 2);
        latch(2);
        chk("beef_data", {48'h0, d16}, 64'hBEEF);
        chk("beef_ferr", {63'h0, fe16}, 64'h0);

        // full 64-bit frame on the wide receiver
        do_rst();
        for (int i = 63; i >= 0; i--) begin
            send_bit(w64[i], 2);
            chk("w64_busy", {63'h0, b64}, 64'h1);
        end
        chk("w64_count", {57'h0, bc64}, 64'd64);
        latch(2);
        chk("w64_data", d64, 64'h0123_4567_89AB_CDEF);
        chk("w64_ferr", {63'h0, fe64}, 64'h0);
        chk("w64_busy_after", {63'h0, b64}, 64'h0);

        for (int f = 0; f < 40; f++) random_frame();
        tick(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_shift_rx.md
Name: serial_shift_rx

Overview:
- Receiver/deserializer for the board's serial shift-chain protocol. This is the protocol the LED and 7-seg drivers transmit on: clock, data, active-low clear and latch-enable lines.
- Oversamples the four serial lines on the system clock and rebuilds the parallel word. The word is presented when the latch strobe rises.
- Used for loopback self-test of the LED/seg transmit path and as the capture front-end for an external serial input chain mapped onto the MIO bus.

Parameters:
- WIDTH, 16, parallel word width, i.e. bits per frame (16 = LED chain, 64 = 7-seg chain).
- SYNC_STAGES, 2, synchronizer flops per serial input (minimum 2).

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  synchronous, active-high reset.
- ser_clk  in  1  serial shift clock, asynchronous to clk.
- ser_data  in  1  serial data, valid at the ser_clk rising edge.
- ser_clrn  in  1  active-low shift-register clear.
- ser_pen  in  1  latch strobe; a rising edge ends the frame.
- data_out  out  WIDTH  last latched parallel word.
- valid  out  1  one-cycle pulse when data_out updates.
- bit_count  out  $clog2(WIDTH+2)  bits received in the current frame, saturating at WIDTH+1.
- frame_err  out  1  set at latch if bit_count != WIDTH; holds until the next latch.
- busy  out  1  high while bit_count != 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Sync chains load their idle levels: ser_clk=0, ser_data=0, ser_pen=0, ser_clrn=1. No false edges are seen after reset.
  - Shift register, bit_count, data_out, valid and frame_err all go to 0.
  - Reset takes effect mid-frame: the partial frame is discarded.
- Synchronization and edge detection:
  - Each input passes through SYNC_STAGES flops plus one history flop.
  - A rising edge is detected on the cycle where sync=1 and history=0.
  - Detection latency is SYNC_STAGES+1 clk cycles after the pin transition.
  - ser_data is sampled from its synchronized copy in the same cycle the ser_clk rising edge is detected. Transmitter guarantee: ser_data is stable from ≥1 cycle before the ser_clk rise until ≥SYNC_STAGES+2 cycles after it.
- Input timing contract: every ser_clk, ser_pen and ser_clrn level must be held for ≥2 clk cycles. Shorter pulses may be missed; this is undefined and not checked.
- Shift on a detected ser_clk rise:
  - sreg <= {sreg[WIDTH-2:0], data}, so the first bit received ends in the MSB (MSB-first protocol).
  - bit_count increments and saturates at WIDTH+1.
  - Bits beyond WIDTH keep shifting: sreg always holds the last WIDTH bits.
- Clear: while synchronized ser_clrn=0, sreg and bit_count are held at 0 every cycle. data_out and frame_err are unaffected.
- Latch on a detected ser_pen rise:
  - data_out <= sreg (including any bit shifted in the same cycle).
  - valid=1 for exactly 1 cycle.
  - frame_err <= (bit_count_next != WIDTH).
  - bit_count <= 0; sreg is kept.
- Simultaneous events, by priority:
  1. rst beats everything.
  2. Clear beats shift; with clear and latch together, the latch captures the cleared value 0 and frame_err=1 unless WIDTH==0.
  3. Shift plus latch in the same cycle: the shift is applied first and the latched word includes the new bit.
- ser_pen falling edge and ser_clk falling edge: no action.
- No FSM beyond this edge-driven datapath.

Test Plan:
- Shift 16 bits of 0xA5C3, MSB first, with ser_clk half-period 5 cycles, then raise ser_pen:
  - valid pulses exactly 1 cycle, 3 cycles after the ser_pen rise;
  - data_out=0xA5C3; frame_err=0; bit_count returns to 0.
- Shift 18 bits (0b11 followed by 0x1234), then latch → data_out=0x1234, frame_err=1. bit_count reads 17 (saturated) just before the latch.
- Shift 8 bits 0xFF, pulse ser_clrn low for 4 cycles, shift 16 bits 0x0F0F, latch:
  - data_out=0x0F0F, frame_err=0;
  - previous data_out is unchanged during the clear.
- Bring ser_clk and ser_pen rising edges into the same cycle on the 16th bit of 0x8001 → data_out=0x8001, frame_err=0.
- Assert rst for 1 cycle after 10 bits, then shift 16 bits 0xBEEF and latch:
  - data_out=0xBEEF, frame_err=0;
  - all outputs are 0 on the cycle after rst.
- With WIDTH=64, shift 0x0123_4567_89AB_CDEF and latch → data_out matches; 64 shift edges counted; busy is high from the first bit until the latch.
